// File: rtl/seg_execute_if.sv
// Execute-stage bus: ID/EX fields and forwarding inputs, plus the EX/MEM outputs.
// The master side drives the instruction; the slave side is the execute stage.
interface seg_execute_if #(
    parameter int LEN        = 32,
    parameter int NB_ADDR    = 5,
    parameter int NB_CTRL_WB = 2,
    parameter int NB_CTRL_M  = 9,
    parameter int NB_CTRL_EX = 6
);
    logic [LEN-1:0]        i_PC;
    logic [LEN-1:0]        i_read_data_1;
    logic [LEN-1:0]        i_read_data_2;
    logic [LEN-1:0]        i_sign_extended;
    logic [4:0]            i_shamt;
    logic [NB_ADDR-1:0]    i_rt;
    logic [NB_ADDR-1:0]    i_rd;
    logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus;
    logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus;
    logic [NB_CTRL_EX-1:0] i_ctrl_ex_bus;
    logic [1:0]            i_fwd_a;
    logic [1:0]            i_fwd_b;
    logic [LEN-1:0]        i_mem_fwd_data;
    logic [LEN-1:0]        i_wb_fwd_data;
    logic                  i_flush;

    logic                  o_stall;
    logic [LEN-1:0]        o_PC_branch;
    logic [LEN-1:0]        o_ALU_result;
    logic [LEN-1:0]        o_write_data;
    logic                  o_ALU_zero;
    logic [NB_ADDR-1:0]    o_write_register;
    logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus;
    logic [NB_CTRL_M-1:0]  o_ctrl_mem_bus;

    modport master (
        output i_PC, i_read_data_1, i_read_data_2, i_sign_extended, i_shamt,
               i_rt, i_rd, i_ctrl_wb_bus, i_ctrl_mem_bus, i_ctrl_ex_bus,
               i_fwd_a, i_fwd_b, i_mem_fwd_data, i_wb_fwd_data, i_flush,
        input  o_stall, o_PC_branch, o_ALU_result, o_write_data, o_ALU_zero,
               o_write_register, o_ctrl_wb_bus, o_ctrl_mem_bus
    );

    modport slave (
        input  i_PC, i_read_data_1, i_read_data_2, i_sign_extended, i_shamt,
               i_rt, i_rd, i_ctrl_wb_bus, i_ctrl_mem_bus, i_ctrl_ex_bus,
               i_fwd_a, i_fwd_b, i_mem_fwd_data, i_wb_fwd_data, i_flush,
        output o_stall, o_PC_branch, o_ALU_result, o_write_data, o_ALU_zero,
               o_write_register, o_ctrl_wb_bus, o_ctrl_mem_bus
    );
endinterface

// File: rtl/seg_execute.sv
// MIPS execute stage: forwarding, ALU, branch target, EX/MEM register and a
// sequential shift-add MULT/MULTU unit with HI/LO that stalls the front end.
module seg_execute #(
    parameter int LEN        = 32,
    parameter int NB_ADDR    = 5,
    parameter int NB_CTRL_WB = 2,
    parameter int NB_CTRL_M  = 9,
    parameter int NB_CTRL_EX = 6
) (
    input  logic i_clk,
    input  logic i_rst,
    seg_execute_if.slave bus
);
    localparam int NB_CNT = $clog2(LEN + 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [NB_CNT-1:0]   r_count;
    logic [2*LEN-1:0]    r_mcand;
    logic [2*LEN-1:0]    r_acc;
    logic [LEN-1:0]      r_mplier;
    logic                r_sign;
    logic [LEN-1:0]      r_hi;
    logic [LEN-1:0]      r_lo;

    logic [LEN-1:0]      r_pc_branch;
    logic [LEN-1:0]      r_alu_result;
    logic [LEN-1:0]      r_write_data;
    logic                r_alu_zero;
    logic [NB_ADDR-1:0]  r_write_register;
    logic [NB_CTRL_WB-1:0] r_ctrl_wb;
    logic [NB_CTRL_M-1:0]  r_ctrl_mem;

    logic [LEN-1:0]      w_op_a;
    logic [LEN-1:0]      w_rt_val;
    logic [LEN-1:0]      w_op_b;
    logic [LEN-1:0]      w_alu_result;
    logic [3:0]          w_alu_ctrl;
    logic                w_reg_dst;
    logic                w_alu_src;
    logic                w_is_mult;
    logic                w_is_signed;
    logic                w_start;
    logic                w_stall;
    logic                w_bubble;
    logic [LEN-1:0]      w_abs_a;
    logic [LEN-1:0]      w_abs_b;
    logic [2*LEN-1:0]    w_acc_step;
    logic [2*LEN-1:0]    w_product;

    assign w_reg_dst  = bus.i_ctrl_ex_bus[NB_CTRL_EX-1];
    assign w_alu_src  = bus.i_ctrl_ex_bus[NB_CTRL_EX-2];
    assign w_alu_ctrl = bus.i_ctrl_ex_bus[3:0];

    // Forwarding select 2'b11 falls back to the register file value.
    always_comb begin
        w_op_a = bus.i_read_data_1;
        case (bus.i_fwd_a)
            2'b01:   w_op_a = bus.i_mem_fwd_data;
            2'b10:   w_op_a = bus.i_wb_fwd_data;
            default: w_op_a = bus.i_read_data_1;
        endcase
        w_rt_val = bus.i_read_data_2;
        case (bus.i_fwd_b)
            2'b01:   w_rt_val = bus.i_mem_fwd_data;
            2'b10:   w_rt_val = bus.i_wb_fwd_data;
            default: w_rt_val = bus.i_read_data_2;
        endcase
    end

    assign w_op_b = w_alu_src ? bus.i_sign_extended : w_rt_val;

    always_comb begin
        w_alu_result = '0;
        case (w_alu_ctrl)
            4'd0:  w_alu_result = w_op_a + w_op_b;
            4'd1:  w_alu_result = w_op_a - w_op_b;
            4'd2:  w_alu_result = w_op_a & w_op_b;
            4'd3:  w_alu_result = w_op_a | w_op_b;
            4'd4:  w_alu_result = w_op_a ^ w_op_b;
            4'd5:  w_alu_result = ~(w_op_a | w_op_b);
            4'd6:  w_alu_result = {{(LEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            4'd7:  w_alu_result = {{(LEN-1){1'b0}}, (w_op_a < w_op_b)};
            4'd8:  w_alu_result = w_op_b << bus.i_shamt;
            4'd9:  w_alu_result = w_op_b >> bus.i_shamt;
            4'd10: w_alu_result = $unsigned($signed(w_op_b) >>> bus.i_shamt);
            4'd11: w_alu_result = w_op_b << 16;
            4'd14: w_alu_result = r_hi;
            4'd15: w_alu_result = r_lo;
            default: w_alu_result = '0;
        endcase
    end

    // Multiplier: operate on magnitudes, apply the sign once at the end.
    assign w_is_mult   = (w_alu_ctrl == 4'd12) || (w_alu_ctrl == 4'd13);
    assign w_is_signed = (w_alu_ctrl == 4'd12);
    assign w_start     = w_is_mult && !bus.i_flush && (r_state == IDLE);
    assign w_abs_a     = (w_is_signed && w_op_a[LEN-1]) ? -w_op_a : w_op_a;
    assign w_abs_b     = (w_is_signed && w_op_b[LEN-1]) ? -w_op_b : w_op_b;
    assign w_acc_step  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_product   = r_sign ? -w_acc_step : w_acc_step;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_next = BUSY;
            BUSY:    if (r_count == NB_CNT'(1)) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_stall = (r_state == BUSY);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_count  <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_sign   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (w_start) begin
            r_count  <= NB_CNT'(LEN);
            r_mcand  <= {{LEN{1'b0}}, w_abs_a};
            r_acc    <= '0;
            r_mplier <= w_abs_b;
            r_sign   <= w_is_signed && (w_op_a[LEN-1] ^ w_op_b[LEN-1]);
        end else if (r_state == BUSY) begin
            r_count  <= r_count - NB_CNT'(1);
            r_mcand  <= r_mcand << 1;
            r_acc    <= w_acc_step;
            r_mplier <= r_mplier >> 1;
            if (r_count == NB_CNT'(1)) {r_hi, r_lo} <= w_product;
        end
    end

    // A bubble reads as a zero result, hence the zero flag set.
    assign w_bubble = bus.i_flush || w_stall;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst || 1'b0) begin
            r_pc_branch      <= '0;
            r_alu_result     <= '0;
            r_write_data     <= '0;
            r_alu_zero       <= 1'b1;
            r_write_register <= '0;
            r_ctrl_wb        <= '0;
            r_ctrl_mem       <= '0;
        end else if (w_bubble) begin
            r_pc_branch      <= '0;
            r_alu_result     <= '0;
            r_write_data     <= '0;
            r_alu_zero       <= 1'b1;
            r_write_register <= '0;
            r_ctrl_wb        <= '0;
            r_ctrl_mem       <= '0;
        end else begin
            r_pc_branch      <= bus.i_PC + bus.i_sign_extended;
            r_alu_result     <= w_alu_result;
            r_write_data     <= w_rt_val;
            r_alu_zero       <= (w_alu_result == '0);
            r_write_register <= w_reg_dst ? bus.i_rd : bus.i_rt;
            r_ctrl_wb        <= bus.i_ctrl_wb_bus;
            r_ctrl_mem       <= bus.i_ctrl_mem_bus;
        end
    end

    assign bus.o_stall          = w_stall;
    assign bus.o_PC_branch      = r_pc_branch;
    assign bus.o_ALU_result     = r_alu_result;
    assign bus.o_write_data     = r_write_data;
    assign bus.o_ALU_zero       = r_alu_zero;
    assign bus.o_write_register = r_write_register;
    assign bus.o_ctrl_wb_bus    = r_ctrl_wb;
    assign bus.o_ctrl_mem_bus   = r_ctrl_mem;
endmodule

// File: tb/tb_seg_execute.sv
// Directed bench for seg_execute: a table of single-cycle ALU vectors, then
// hand-written multiplier, flush and mid-multiply reset sequences.
module tb_seg_execute;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    seg_execute_if bus ();

    seg_execute dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  ex;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sext;
        logic [4:0]  shamt;
        logic [31:0] memf;
        logic [31:0] wbf;
        logic [31:0] pc;
        logic        flush;
        logic [31:0] e_res;
        logic        e_zero;
        logic [31:0] e_br;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(string name, logic [5:0] ex, logic [1:0] fa, logic [1:0] fb,
                                logic [31:0] rd1, logic [31:0] rd2, logic [31:0] sext,
                                logic [4:0] shamt, logic [31:0] memf, logic [31:0] wbf,
                                logic [31:0] pc, logic flush, logic [31:0] e_res,
                                logic e_zero, logic [31:0] e_br, logic [31:0] e_wd);
        vec_t v;
        v.name = name; v.ex = ex; v.fa = fa; v.fb = fb; v.rd1 = rd1; v.rd2 = rd2;
        v.sext = sext; v.shamt = shamt; v.memf = memf; v.wbf = wbf; v.pc = pc;
        v.flush = flush; v.e_res = e_res; v.e_zero = e_zero; v.e_br = e_br; v.e_wd = e_wd;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_PC = '0; bus.i_read_data_1 = '0; bus.i_read_data_2 = '0;
        bus.i_sign_extended = '0; bus.i_shamt = '0; bus.i_rt = '0; bus.i_rd = '0;
        bus.i_ctrl_wb_bus = '0; bus.i_ctrl_mem_bus = '0; bus.i_ctrl_ex_bus = '0;
        bus.i_fwd_a = '0; bus.i_fwd_b = '0; bus.i_mem_fwd_data = '0;
        bus.i_wb_fwd_data = '0; bus.i_flush = 1'b0;
    endtask

    // Present MFHI (ex=0E) or MFLO (ex=0F) for one cycle and check the result.
    task automatic read_hilo(logic [5:0] ex, logic [31:0] exp, string name);
        clear_inputs();
        bus.i_ctrl_ex_bus = ex;
        bus.i_ctrl_wb_bus = 2'b10;
        tick();
        chk(name, bus.o_ALU_result, exp);
        chk({name, "_stall"}, {31'b0, bus.o_stall}, 32'd0);
        $display("%s result=%h", name, bus.o_ALU_result);
    endtask

    // Full multiply: stall length, bubbles while busy, then HI and LO.
    task automatic do_mult(string name, logic [31:0] a, logic [31:0] b, logic uns,
                           logic [31:0] e_hi, logic [31:0] e_lo);
        int  cnt;
        bit  stalled;
        clear_inputs();
        bus.i_read_data_1 = a;
        bus.i_read_data_2 = b;
        bus.i_ctrl_ex_bus = uns ? 6'h0D : 6'h0C;
        tick();
        chk({name, "_stall_rise"}, {31'b0, bus.o_stall}, 32'd1);
        cnt = bus.o_stall ? 1 : 0;
        stalled = bus.o_stall;
        // The following MFHI waits at the inputs through the stall.
        bus.i_ctrl_ex_bus = 6'h0E;
        bus.i_ctrl_wb_bus = 2'b10;
        bus.i_ctrl_mem_bus = 9'h003;
        for (int k = 0; k < 40 && stalled; k++) begin
            tick();
            chk({name, "_bubble_wb"}, {30'b0, bus.o_ctrl_wb_bus}, 32'd0);
            chk({name, "_bubble_res"}, bus.o_ALU_result, 32'd0);
            if (bus.o_stall) cnt++;
            else stalled = 1'b0;
        end
        chk({name, "_stall_len"}, cnt, 32'd32);
        tick();
        chk({name, "_hi"}, bus.o_ALU_result, e_hi);
        chk({name, "_wb_after"}, {30'b0, bus.o_ctrl_wb_bus}, 32'd2);
        $display("%s a=%h b=%h stall_cycles=%0d hi=%h", name, a, b, cnt, bus.o_ALU_result);
        read_hilo(6'h0F, e_lo, {name, "_lo"});
    endtask

    initial begin
        logic [1:0]  wb;
        logic [8:0]  mem;
        logic [4:0]  e_wreg;

        vecs[0]  = mk("add",    6'h00, 2'd0, 2'd0, 32'd5, 32'd7, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0,
                      32'h0000000C, 1'b0, 32'd0, 32'd7);
        vecs[1]  = mk("sub",    6'h21, 2'd0, 2'd0, 32'h1234, 32'h1234, 32'hFFFFFFFD, 5'd0, 32'd0, 32'd0, 32'd10, 1'b0,
                      32'd0, 1'b1, 32'd7, 32'h1234);
        vecs[2]  = mk("slt",    6'h06, 2'd1, 2'd2, 32'h99, 32'h77, 32'd0, 5'd0, 32'hF6F6F6F6, 32'd1, 32'd0, 1'b0,
                      32'd1, 1'b0, 32'd0, 32'd1);
        vecs[3]  = mk("sltu",   6'h07, 2'd1, 2'd2, 32'h99, 32'h77, 32'd0, 5'd0, 32'hF6F6F6F6, 32'd1, 32'd0, 1'b0,
                      32'd0, 1'b1, 32'd0, 32'd1);
        vecs[4]  = mk("and",    6'h02, 2'd0, 2'd0, 32'hFF00FF00, 32'h0FF00FF0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0,
                      32'h0F000F00, 1'b0, 32'd0, 32'h0FF00FF0);
        vecs[5]  = mk("or",     6'h03, 2'd0, 2'd0, 32'hFF00FF00, 32'h0FF00FF0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0,
                      32'hFFF0FFF0, 1'b0, 32'd0, 32'h0FF00FF0);
        vecs[6]  = mk("xor",    6'h04, 2'd0, 2'd0, 32'hFF00FF00, 32'h0FF00FF0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0,
                      32'hF0F0F0F0, 1'b0, 32'd0, 32'h0FF00FF0);
        vecs[7]  = mk("nor",    6'h05, 2'd0, 2'd0, 32'hFF00FF00, 32'h0FF00FF0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0,
                      32'h000F000F, 1'b0, 32'd0, 32'h0FF00FF0);
        vecs[8]  = mk("sll",    6'h18, 2'd0, 2'd0, 32'd0, 32'h55, 32'h80000001, 5'd4, 32'd0, 32'd0, 32'd0, 1'b0,
                      32'h00000010, 1'b0, 32'h80000001, 32'h55);
        vecs[9]  = mk("srl",    6'h19, 2'd0, 2'd0, 32'd0, 32'h55, 32'h80000010, 5'd4, 32'd0, 32'd0, 32'd0, 1'b0,
                      32'h08000001, 1'b0, 32'h80000010, 32'h55);
        vecs[10] = mk("sra",    6'h1A, 2'd0, 2'd0, 32'd0, 32'h55, 32'h80000010, 5'd4, 32'd0, 32'd0, 32'd0, 1'b0,
                      32'hF8000001, 1'b0, 32'h80000010, 32'h55);
        vecs[11] = mk("lui",    6'h1B, 2'd0, 2'd0, 32'd0, 32'h55, 32'h00001234, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0,
                      32'h12340000, 1'b0, 32'h00001234, 32'h55);
        vecs[12] = mk("fwd11",  6'h00, 2'd3, 2'd3, 32'd3, 32'd4, 32'd0, 5'd0, 32'd100, 32'd200, 32'd0, 1'b0,
                      32'd7, 1'b0, 32'd0, 32'd4);
        vecs[13] = mk("addi0",  6'h10, 2'd0, 2'd0, 32'd5, 32'd9, 32'hFFFFFFFB, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0,
                      32'd0, 1'b1, 32'hFFFFFFFB, 32'd9);
        vecs[14] = mk("flushlw", 6'h10, 2'd0, 2'd0, 32'd100, 32'd9, 32'd4, 5'd0, 32'd0, 32'd0, 32'd8, 1'b1,
                      32'd0, 1'b1, 32'd0, 32'd0);

        clear_inputs();
        #12;
        chk("rst_stall", {31'b0, bus.o_stall}, 32'd0);
        chk("rst_zero",  {31'b0, bus.o_ALU_zero}, 32'd1);
        chk("rst_res",   bus.o_ALU_result, 32'd0);
        chk("rst_wb",    {30'b0, bus.o_ctrl_wb_bus}, 32'd0);
        chk("rst_mem",   {23'b0, bus.o_ctrl_mem_bus}, 32'd0);
        $display("reset stall=%b zero=%b res=%h", bus.o_stall, bus.o_ALU_zero, bus.o_ALU_result);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 15; i++) begin
            wb  = 2'(i + 1);
            mem = (9'(i) << 2) | 9'h002;
            clear_inputs();
            bus.i_ctrl_ex_bus   = vecs[i].ex;
            bus.i_fwd_a         = vecs[i].fa;
            bus.i_fwd_b         = vecs[i].fb;
            bus.i_read_data_1   = vecs[i].rd1;
            bus.i_read_data_2   = vecs[i].rd2;
            bus.i_sign_extended = vecs[i].sext;
            bus.i_shamt         = vecs[i].shamt;
            bus.i_mem_fwd_data  = vecs[i].memf;
            bus.i_wb_fwd_data   = vecs[i].wbf;
            bus.i_PC            = vecs[i].pc;
            bus.i_flush         = vecs[i].flush;
            bus.i_rt            = 5'(i);
            bus.i_rd            = 5'(i + 16);
            bus.i_ctrl_wb_bus   = wb;
            bus.i_ctrl_mem_bus  = mem;
            e_wreg = vecs[i].flush ? 5'd0 : (vecs[i].ex[5] ? 5'(i + 16) : 5'(i));
            tick();
            chk({vecs[i].name, "_res"},  bus.o_ALU_result, vecs[i].e_res);
            chk({vecs[i].name, "_zero"}, {31'b0, bus.o_ALU_zero}, {31'b0, vecs[i].e_zero});
            chk({vecs[i].name, "_br"},   bus.o_PC_branch, vecs[i].e_br);
            chk({vecs[i].name, "_wd"},   bus.o_write_data, vecs[i].e_wd);
            chk({vecs[i].name, "_wreg"}, {27'b0, bus.o_write_register}, {27'b0, e_wreg});
            chk({vecs[i].name, "_wb"},   {30'b0, bus.o_ctrl_wb_bus}, vecs[i].flush ? 32'd0 : {30'b0, wb});
            chk({vecs[i].name, "_mem"},  {23'b0, bus.o_ctrl_mem_bus}, vecs[i].flush ? 32'd0 : {23'b0, mem});
            $display("vec %s res=%h zero=%b br=%h wd=%h wreg=%0d", vecs[i].name,
                     bus.o_ALU_result, bus.o_ALU_zero, bus.o_PC_branch, bus.o_write_data,
                     bus.o_write_register);
        end

        do_mult("mult",  32'hFFFFFFFD, 32'h7FFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h80000003);
        do_mult("multu", 32'hFFFFFFFF, 32'h00000002, 1'b1, 32'h00000001, 32'hFFFFFFFE);

        // Flushed MULT must not start the unit.
        clear_inputs();
        bus.i_read_data_1 = 32'd3;
        bus.i_read_data_2 = 32'd3;
        bus.i_ctrl_ex_bus = 6'h0C;
        bus.i_flush = 1'b1;
        tick();
        chk("fmult_stall", {31'b0, bus.o_stall}, 32'd0);
        chk("fmult_zero",  {31'b0, bus.o_ALU_zero}, 32'd1);
        $display("flushed mult stall=%b", bus.o_stall);
        read_hilo(6'h0E, 32'h00000001, "fmult_hi");
        read_hilo(6'h0F, 32'hFFFFFFFE, "fmult_lo");

        // Asynchronous reset in the tenth busy cycle.
        clear_inputs();
        bus.i_read_data_1 = 32'h12345678;
        bus.i_read_data_2 = 32'd3;
        bus.i_ctrl_ex_bus = 6'h0C;
        tick();
        chk("rmult_stall", {31'b0, bus.o_stall}, 32'd1);
        bus.i_ctrl_ex_bus = 6'h0E;
        for (int k = 0; k < 9; k++) tick();
        chk("rmult_busy", {31'b0, bus.o_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rmult_drop", {31'b0, bus.o_stall}, 32'd0);
        chk("rmult_zero", {31'b0, bus.o_ALU_zero}, 32'd1);
        $display("reset mid-mult stall=%b", bus.o_stall);
        @(negedge clk);
        rst_n = 1'b1;
        read_hilo(6'h0E, 32'd0, "rmult_hi");
        read_hilo(6'h0F, 32'd0, "rmult_lo");

        do_mult("mult2", 32'd7, 32'hFFFFFFFA, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFD6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_execute.md
# seg_execute

Execute stage of the five-stage MIPS pipeline. It sits between the ID/EX register and `seg_memory_access`, and owns the EX/MEM pipeline register. It resolves operand forwarding, computes the ALU result, the zero flag and the branch target, and selects the destination register. It also contains a sequential 32-cycle MULT/MULTU unit with HI/LO registers, which stalls the front end while busy.

## Interface
- `LEN`, 32, datapath width.
- `NB_ADDR`, 5, register address width.
- `NB_CTRL_WB`, 2, WB control width: [RegWrite, MemtoReg].
- `NB_CTRL_M`, 9, MEM control width: [SB, SH, LB, LH, Unsigned, BNEQ, Branch, MemRead, MemWrite].
- `NB_CTRL_EX`, 6, EX control width: [RegDst, ALUSrc, ALUCtrl[3:0]].
- `i_clk`  in  1  the single clock; all state changes on the rising edge.
- `i_rst`  in  1  reset, asynchronous and active-low.
- `i_PC`  in  LEN  PC+1 of the instruction (word address).
- `i_read_data_1`, `i_read_data_2`  in  LEN  rs and rt register-file values.
- `i_sign_extended`  in  LEN  sign-extended immediate.
- `i_shamt`  in  5  shift amount.
- `i_rt`, `i_rd`  in  NB_ADDR  destination candidates.
- `i_ctrl_wb_bus`  in  NB_CTRL_WB  passed through to the EX/MEM register.
- `i_ctrl_mem_bus`  in  NB_CTRL_M  passed through to the EX/MEM register.
- `i_ctrl_ex_bus`  in  NB_CTRL_EX  consumed in this stage.
- `i_fwd_a`, `i_fwd_b`  in  2  operand source: 00 register file, 01 `i_mem_fwd_data`, 10 `i_wb_fwd_data`, 11 treated as 00.
- `i_mem_fwd_data`, `i_wb_fwd_data`  in  LEN  forwarded results.
- `i_flush`  in  1  squash the instruction currently in EX (taken branch resolved in MEM).
- `o_stall`  out  1  multiplier busy; upstream must freeze PC, IF/ID and ID/EX.
- `o_PC_branch`, `o_ALU_result`, `o_write_data`  out  LEN  EX/MEM fields.
- `o_ALU_zero`  out  1  EX/MEM field.
- `o_write_register`  out  NB_ADDR  EX/MEM field.
- `o_ctrl_wb_bus`, `o_ctrl_mem_bus`  out  EX/MEM control fields.

## Operation
**Operands**
- A = forward mux selected by `i_fwd_a`.
- Rt value = forward mux selected by `i_fwd_b`.
- B = ALUSrc ? `i_sign_extended` : rt value.

**ALUCtrl encodings**
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
- 6 SLT (signed, result 0/1), 7 SLTU.
- 8 SLL, 9 SRL, 10 SRA: shift B by `i_shamt`.
- 11 LUI: B<<16.
- 12 MULT, 13 MULTU.
- 14 MFHI, 15 MFLO.
- All arithmetic is modulo 2^LEN; overflow is ignored.

**Derived fields**
- Zero = (result == 0).
- Branch target = `i_PC` + `i_sign_extended`, word addressed with no shift, modulo 2^LEN.
- Write register = RegDst ? `i_rd` : `i_rt`.
- `o_write_data` = forwarded rt value (store data).

**EX/MEM register**
- Normal cycle: all fields load.
- Bubble: every output field loads 0, except `o_ALU_zero`, which loads 1 because it reflects the zero result.
- A bubble is loaded when `i_flush`=1 or `o_stall`=1.

**Multiplier FSM**, states IDLE and BUSY
- IDLE→BUSY: ALUCtrl∈{12,13}, `i_flush`=0, state IDLE.
  - Latch magnitudes of A and B (MULTU takes raw values).
  - Latch the product sign for MULT.
  - Counter = LEN.
- BUSY: one shift-add step per cycle; counter decrements.
- Counter reaches 0:
  - {HI,LO} = 64-bit product, two's-complement negated if the sign bit is set.
  - Go to IDLE.
- The MULT instruction itself passes to EX/MEM with its own (zero) WB/MEM control.
- `i_flush` while BUSY: ignored; the multiply belongs to an older instruction.
- MFHI/MFLO return HI/LO combinationally.

**Reset** (`i_rst`=0)
- FSM to IDLE; counter, HI and LO cleared.
- `o_stall`=0.
- All EX/MEM outputs 0, except `o_ALU_zero`=1.

## Timing
- ALU path is combinational; EX/MEM outputs are valid 1 cycle after the instruction is presented.
- MULT presented in cycle T (edge ending T starts the FSM):
  - `o_stall` is registered and high in cycles T+1..T+LEN, exactly LEN cycles.
  - HI/LO are updated at the edge ending T+LEN.
  - `o_stall`=0 in T+LEN+1.
- Instruction following MULT: held at the inputs through the stall; it is latched at the edge ending T+LEN+1.
- MFHI in T+LEN+1 sees the new HI.
- While `o_stall`=1, no non-bubble value enters EX/MEM.
- A second MULT is only accepted once the FSM is IDLE, which is guaranteed by the stall.
- MULT with `i_flush`=1 in T: FSM stays IDLE, `o_stall` never rises, HI/LO unchanged.
- Asynchronous reset mid-BUSY: `o_stall` falls immediately; the partial product is discarded.

## Test plan
- Reset low then high; ADD with A=5, B=7 (`i_fwd_a`=`i_fwd_b`=00) -> next cycle `o_ALU_result`=12, `o_ALU_zero`=0, ctrl buses match the inputs.
- SUB with A=B=0x1234, `i_PC`=10, imm=0xFFFFFFFD -> `o_ALU_zero`=1, `o_PC_branch`=7.
- `i_fwd_a`=01 with `i_mem_fwd_data`=0xF6F6F6F6; `i_fwd_b`=10 with `i_wb_fwd_data`=1; SLT -> result 1.
  - Repeat with SLTU -> result 0.
- MULT with A=-3, B=0x7FFFFFFF -> `o_stall` high exactly 32 cycles, bubbles in EX/MEM; then MFHI=0xFFFFFFFE and MFLO=0x80000003.
  - MULTU 0xFFFFFFFF×2 -> HI=1, LO=0xFFFFFFFE.
- `i_flush`=1 during a LW (MemRead=1) -> EX/MEM ctrl buses = 0.
  - `i_flush` with MULT -> no stall, HI/LO unchanged.
- Assert `i_rst`=0 at cycle 10 of a MULT -> `o_stall`=0 immediately, HI=LO=0; a new MULT afterwards completes correctly.
